// File: rtl/ula_seq_ctrl.sv
// ----------------------------------------------------------------------------
// ula_seq_ctrl -- multicycle control FSM for the shared ALU (ULA) datapath.
//
// Walks each instruction through FETCH / DECODE / execute / memory / write-back
// phases and drives the datapath mux selects, ALU op and write strobes. The
// outputs are decoded from the current state. Three inputs also act within a
// cycle:
//   - mem_ready completes the FETCH handshake (ir_write, pc_write).
//   - funct picks the ALU op in EXEC_R.
//   - zero resolves the branch pc_write in BRANCH.
// While reset_n is low every output is forced to its idle value.
//
// Optional feature: define ULA_SEQ_STALL_CNT_EN to build a saturating counter
// of memory wait cycles on stall_count. When it is not defined, stall_count is
// tied to zero.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   opcode       IR[31:26]
//   funct        IR[5:0]
//   zero         ALU zero flag, same cycle as the op
//   mem_ready    memory handshake, sampled only in FETCH / MEM_RD / MEM_WR
//   ula1_sel     operand A select: 00=PC, 01=A, 10=const 0
//   ula2_sel     operand B select: 000=B, 001=4, 010=sext imm, 011=imm<<2,
//                100=imm<<16
//   ula_op       001 add, 010 sub, 011 and, 100 or, 101 slt
//   pc_write     PC load strobe
//   pc_src       00=ALU result, 01=ALUOut, 10=jump target, 11=exc_vector
//   ir_write, mem_read, mem_write, reg_write, aluout_write, epc_write  strobes
//   reg_dst      destination register: 0=rt, 1=rd
//   mem_to_reg   write-back source: 0=ALUOut, 1=MDR
//   exc_vector   constant VEC_EXC
//   state        current state encoding (debug)
//   stall_count  memory wait-cycle counter (optional feature)
// ----------------------------------------------------------------------------
module ula_seq_ctrl #(
  parameter logic [31:0] VEC_EXC = 32'h0000_00FC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  ula1_sel,
  output logic [2:0]  ula2_sel,
  output logic [2:0]  ula_op,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        aluout_write,
  output logic        epc_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic [31:0] exc_vector,
  output logic [3:0]  state,
  output logic [15:0] stall_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_LUI      = 4'd12,
    S_EXCEPT   = 4'd13
  } state_t;

  // Opcodes
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // Operand A selects
  localparam logic [1:0] A_PC   = 2'b00;
  localparam logic [1:0] A_REG  = 2'b01;
  localparam logic [1:0] A_ZERO = 2'b10;

  // Operand B selects
  localparam logic [2:0] B_REG   = 3'b000;
  localparam logic [2:0] B_FOUR  = 3'b001;
  localparam logic [2:0] B_SEXT  = 3'b010;
  localparam logic [2:0] B_IMM2  = 3'b011;
  localparam logic [2:0] B_IMM16 = 3'b100;

  // ALU ops
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  // PC sources
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;

  state_t     state_q;
  logic       funct_valid;
  logic [2:0] funct_op;

  // R-type funct decode. An unlisted funct is flagged invalid and traps.
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    funct_valid = 1'b1;
    funct_op    = OP_ADD;
    case (funct)
      6'h20:   funct_op = OP_ADD;
      6'h22:   funct_op = OP_SUB;
      6'h24:   funct_op = OP_AND;
      6'h25:   funct_op = OP_OR;
      6'h2A:   funct_op = OP_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  // State register and transitions.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OPC_RTYPE:      state_q <= S_EXEC_R;
            OPC_ADDI:       state_q <= S_EXEC_I;
            OPC_LW, OPC_SW: state_q <= S_MEM_ADDR;
            OPC_BEQ,
            OPC_BNE:        state_q <= S_BRANCH;
            OPC_J:          state_q <= S_JUMP;
            OPC_LUI:        state_q <= S_LUI;
            default:        state_q <= S_EXCEPT;
          endcase
        end
        S_EXEC_R: state_q <= funct_valid ? S_WB_R : S_EXCEPT;
        S_EXEC_I: state_q <= S_WB_I;
        S_LUI:    state_q <= S_WB_I;
        S_MEM_ADDR: begin
          // The opcode is stable from IR; anything other than lw/sw here can
          // only come from a corrupted IR, so treat it as invalid.
          if (opcode == OPC_LW)      state_q <= S_MEM_RD;
          else if (opcode == OPC_SW) state_q <= S_MEM_WR;
          else                       state_q <= S_EXCEPT;
        end
        S_MEM_RD: if (mem_ready) state_q <= S_WB_MEM;
        S_MEM_WR: if (mem_ready) state_q <= S_FETCH;
        // WB_R, WB_I, WB_MEM, BRANCH, JUMP, EXCEPT and the unused codes 14/15
        // all return to FETCH.
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Output decode. The defaults are the idle/reset values. Gating the whole
  // decode with reset_n keeps every strobe low from the reset edge onwards,
  // including FETCH's mem_read.
  always_comb begin
    ula1_sel     = A_PC;
    ula2_sel     = B_REG;
    ula_op       = OP_ADD;
    pc_write     = 1'b0;
    pc_src       = PC_ALU;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    aluout_write = 1'b0;
    epc_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          ula1_sel = A_PC;
          ula2_sel = B_FOUR;
          ula_op   = OP_ADD;
          // IR and PC load only on the cycle the fetch completes.
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_ALU;
          end
        end
        S_DECODE: begin
          // Branch target computed speculatively while the opcode decodes.
          ula1_sel     = A_PC;
          ula2_sel     = B_IMM2;
          ula_op       = OP_ADD;
          aluout_write = 1'b1;
        end
        S_EXEC_R: begin
          ula1_sel     = A_REG;
          ula2_sel     = B_REG;
          ula_op       = funct_op;
          aluout_write = funct_valid;
        end
        S_EXEC_I, S_MEM_ADDR: begin
          ula1_sel     = A_REG;
          ula2_sel     = B_SEXT;
          ula_op       = OP_ADD;
          aluout_write = 1'b1;
        end
        S_LUI: begin
          // 0 + (imm << 16) places the immediate in the upper half.
          ula1_sel     = A_ZERO;
          ula2_sel     = B_IMM16;
          ula_op       = OP_ADD;
          aluout_write = 1'b1;
        end
        S_MEM_RD: mem_read  = 1'b1;
        S_MEM_WR: mem_write = 1'b1;
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_WB_I: reg_write = 1'b1;
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          // A - B sets zero; ALUOut already holds the target from DECODE.
          ula1_sel = A_REG;
          ula2_sel = B_REG;
          ula_op   = OP_SUB;
          pc_src   = PC_ALUOUT;
          pc_write = (opcode == OPC_BNE) ? ~zero : zero;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
        end
        S_EXCEPT: begin
          epc_write = 1'b1;
          pc_write  = 1'b1;
          pc_src    = PC_EXC;
        end
        default: ;
      endcase
    end
  end

  assign exc_vector = VEC_EXC;
  assign state      = state_q;

`ifdef ULA_SEQ_STALL_CNT_EN
  // A stall is any cycle a memory-waiting state holds for mem_ready.
  logic        stalled;
  logic [15:0] stall_q;

  assign stalled = ((state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                    (state_q == S_MEM_WR)) && !mem_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           stall_q <= 16'h0000;
    else if (stalled && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ula_seq_ctrl -- directed self-checking bench for ula_seq_ctrl.
// Each step pushes the expected output vector for the coming cycle into a
// scoreboard queue. The entry is popped and compared on the falling edge,
// while the current state's outputs are stable.
// ----------------------------------------------------------------------------
module tb_ula_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic [5:0]  funct = 6'h20;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic [1:0]  ula1_sel;
  logic [2:0]  ula2_sel;
  logic [2:0]  ula_op;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write, mem_read, mem_write, reg_write;
  logic        aluout_write, epc_write, reg_dst, mem_to_reg;
  logic [31:0] exc_vector;
  logic [3:0]  state;
  logic [15:0] stall_count;

  ula_seq_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .ula1_sel     (ula1_sel),
    .ula2_sel     (ula2_sel),
    .ula_op       (ula_op),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .ir_write     (ir_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .aluout_write (aluout_write),
    .epc_write    (epc_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .exc_vector   (exc_vector),
    .state        (state),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

`ifdef ULA_SEQ_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [1:0] A_PC = 2'b00, A_REG = 2'b01, A_ZERO = 2'b10;
  localparam logic [2:0] B_REG = 3'b000, B_FOUR = 3'b001, B_SEXT = 3'b010;
  localparam logic [2:0] B_IMM2 = 3'b011, B_IMM16 = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b001, OP_SUB = 3'b010, OP_AND = 3'b011;
  localparam logic [2:0] OP_OR = 3'b100, OP_SLT = 3'b101;
  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP = 2'b10, PC_EXC = 2'b11;

  typedef struct {
    string       tag;
    logic [22:0] exp;
  } sb_t;

  sb_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;

  // Vector layout: state, ula1, ula2, op, pc_write, pc_src, ir_write, mem_read,
  // mem_write, reg_write, aluout_write, epc_write, reg_dst, mem_to_reg.
  function automatic logic [22:0] mk(input logic [3:0] st, input logic [1:0] a,
                                     input logic [2:0] b, input logic [2:0] op,
                                     input logic pw, input logic [1:0] ps,
                                     input logic irw, input logic mr,
                                     input logic mw, input logic rw,
                                     input logic aw, input logic ew,
                                     input logic rd, input logic m2r);
    return {st, a, b, op, pw, ps, irw, mr, mw, rw, aw, ew, rd, m2r};
  endfunction

  function automatic logic [22:0] e_exec_r(input logic [2:0] op, input logic aw);
    return mk(4'd2, A_REG, B_REG, op, 1'b0, PC_ALU, 1'b0, 1'b0, 1'b0, 1'b0, aw, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [22:0] e_branch(input logic pw);
    return mk(4'd10, A_REG, B_REG, OP_SUB, pw, PC_ALUOUT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  logic [22:0] e_reset, e_fetch, e_fetch_wait, e_decode, e_wb_r, e_exec_i, e_wb_i;
  logic [22:0] e_lui, e_mem_addr, e_mem_rd, e_mem_wr, e_wb_mem, e_jump, e_except;

  initial begin
    e_reset      = mk(4'd0,  A_PC,   B_REG,   OP_ADD, 1'b0, PC_ALU,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_fetch      = mk(4'd0,  A_PC,   B_FOUR,  OP_ADD, 1'b1, PC_ALU,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_fetch_wait = mk(4'd0,  A_PC,   B_FOUR,  OP_ADD, 1'b0, PC_ALU,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_decode     = mk(4'd1,  A_PC,   B_IMM2,  OP_ADD, 1'b0, PC_ALU,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e_exec_i     = mk(4'd3,  A_REG,  B_SEXT,  OP_ADD, 1'b0, PC_ALU,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e_mem_addr   = mk(4'd4,  A_REG,  B_SEXT,  OP_ADD, 1'b0, PC_ALU,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e_mem_rd     = mk(4'd5,  A_PC,   B_REG,   OP_ADD, 1'b0, PC_ALU,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_mem_wr     = mk(4'd6,  A_PC,   B_REG,   OP_ADD, 1'b0, PC_ALU,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_wb_r       = mk(4'd7,  A_PC,   B_REG,   OP_ADD, 1'b0, PC_ALU,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    e_wb_i       = mk(4'd8,  A_PC,   B_REG,   OP_ADD, 1'b0, PC_ALU,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    e_wb_mem     = mk(4'd9,  A_PC,   B_REG,   OP_ADD, 1'b0, PC_ALU,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    e_jump       = mk(4'd11, A_PC,   B_REG,   OP_ADD, 1'b1, PC_JUMP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_lui        = mk(4'd12, A_ZERO, B_IMM16, OP_ADD, 1'b0, PC_ALU,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e_except     = mk(4'd13, A_PC,   B_REG,   OP_ADD, 1'b1, PC_EXC,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  end

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic compare_head();
    sb_t         h;
    logic [22:0] obs;
    h   = sb.pop_front();
    obs = {state, ula1_sel, ula2_sel, ula_op, pc_write, pc_src, ir_write, mem_read,
           mem_write, reg_write, aluout_write, epc_write, reg_dst, mem_to_reg};
    vectors++;
    assert (obs === h.exp) else begin
      miscompares++;
      $error("FAIL %s: observed %06h expected %06h (state %0d vs %0d)",
             h.tag, obs, h.exp, obs[22:19], h.exp[22:19]);
    end
  endtask

  // One clock cycle. Inputs are already driven; outputs are sampled at the
  // falling edge and the task returns 1 ns after the next rising edge.
  task automatic step(input string tag, input logic [22:0] e);
    sb_t item;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stall(input string tag, input int n);
    logic [15:0] e;
    e = CNT_EN ? 16'(n) : 16'h0000;
    vectors++;
    assert (stall_count === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, stall_count, e);
    end
  endtask

  logic [5:0] fn_tab[4] = '{6'h22, 6'h24, 6'h25, 6'h2A};
  logic [2:0] op_tab[4] = '{OP_SUB, OP_AND, OP_OR, OP_SLT};
  logic [5:0] br_opc[4] = '{6'h04, 6'h04, 6'h05, 6'h05};
  logic       br_z[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic       br_pw[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    #1;
    // Reset state
    step("reset", e_reset);
    chk_stall("stall_reset", 0);
    reset_n = 1'b1;

    // R-type add: 0,1,2,7,0
    opcode = 6'h00; funct = 6'h20;
    step("add_fetch", e_fetch);
    step("add_decode", e_decode);
    step("add_exec", e_exec_r(OP_ADD, 1'b1));
    step("add_wb", e_wb_r);

    // Remaining R-type functs
    for (int i = 0; i < 4; i++) begin
      funct = fn_tab[i];
      step($sformatf("r%0d_fetch", i), e_fetch);
      step($sformatf("r%0d_decode", i), e_decode);
      step($sformatf("r%0d_exec", i), e_exec_r(op_tab[i], 1'b1));
      step($sformatf("r%0d_wb", i), e_wb_r);
    end

    // addi
    opcode = 6'h08;
    step("addi_fetch", e_fetch);
    step("addi_decode", e_decode);
    step("addi_exec", e_exec_i);
    step("addi_wb", e_wb_i);

    // lui
    opcode = 6'h0F;
    step("lui_fetch", e_fetch);
    step("lui_decode", e_decode);
    step("lui_exec", e_lui);
    step("lui_wb", e_wb_i);

    // lw, three wait cycles in MEM_RD
    opcode = 6'h23;
    step("lw_fetch", e_fetch);
    step("lw_decode", e_decode);
    step("lw_addr", e_mem_addr);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step($sformatf("lw_wait%0d", i), e_mem_rd);
    mem_ready = 1'b1;
    step("lw_rd_done", e_mem_rd);
    step("lw_wb", e_wb_mem);
    chk_stall("stall_lw", 3);

    // sw, two wait cycles in FETCH, one in MEM_WR
    opcode = 6'h2B;
    mem_ready = 1'b0;
    step("sw_fwait0", e_fetch_wait);
    step("sw_fwait1", e_fetch_wait);
    mem_ready = 1'b1;
    step("sw_fetch", e_fetch);
    step("sw_decode", e_decode);
    step("sw_addr", e_mem_addr);
    mem_ready = 1'b0;
    step("sw_wait", e_mem_wr);
    mem_ready = 1'b1;
    step("sw_wr_done", e_mem_wr);
    chk_stall("stall_sw", 6);

    // beq/bne with zero set and clear
    for (int k = 0; k < 4; k++) begin
      opcode = br_opc[k];
      zero   = br_z[k];
      step($sformatf("br%0d_fetch", k), e_fetch);
      step($sformatf("br%0d_decode", k), e_decode);
      step($sformatf("br%0d_branch", k), e_branch(br_pw[k]));
    end
    zero = 1'b0;

    // j
    opcode = 6'h02;
    step("j_fetch", e_fetch);
    step("j_decode", e_decode);
    step("j_jump", e_jump);

    // Invalid opcode
    opcode = 6'h3F;
    step("inv_fetch", e_fetch);
    step("inv_decode", e_decode);
    vectors++;
    assert (exc_vector === 32'h0000_00FC) else begin
      miscompares++;
      $error("FAIL exc_vector: observed %08h expected %08h", exc_vector, 32'h0000_00FC);
    end
    step("inv_except", e_except);

    // Invalid funct
    opcode = 6'h00; funct = 6'h07;
    step("badf_fetch", e_fetch);
    step("badf_decode", e_decode);
    step("badf_exec", e_exec_r(OP_ADD, 1'b0));
    step("badf_except", e_except);

    // Reset dropped while MEM_WR waits
    opcode = 6'h2B; funct = 6'h20;
    step("rst_fetch", e_fetch);
    step("rst_decode", e_decode);
    step("rst_addr", e_mem_addr);
    mem_ready = 1'b0;
    step("rst_wr_wait", e_mem_wr);
    reset_n = 1'b0;
    step("rst_abort", e_reset);
    chk_stall("stall_after_rst", 0);
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    step("post_rst_fetch", e_fetch);
    step("post_rst_decode", e_decode);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
